// File: rtl/rename_reg_file.sv
// ---------------------------------------------------------------------------
// rename_reg_file
//
// Architectural register file with per-register rename state for an
// out-of-order core. Each of the 32 registers holds a 32-bit value, a busy bit
// and the 4-bit reorder-buffer tag of its youngest in-flight writer.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   rdy                 global enable; low freezes all state
//   clear               mispredict flush: drops every busy bit, blocks issue
//   issue_en/_rd/_rob_id    rename the destination of a dispatched instruction
//   rs1_id, rs2_id      source indices, read combinationally
//   rs1_val/_busy/_tag  source 1 value, pending flag and producer tag
//   rs2_val/_busy/_tag  source 2 value, pending flag and producer tag
//   commit_en/_rd/_rob_id/_val  retire a result into the architectural state
//
// Configuration
//   RF_COMMIT_BYPASS_EN  when defined, a commit whose tag matches the current
//                        producer of a read source is forwarded to that read
//                        port in the same cycle. Undefined: reads show only
//                        the state registered before this edge.
// ---------------------------------------------------------------------------
module rename_reg_file (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic        issue_en,
    input  logic [4:0]  issue_rd,
    input  logic [3:0]  issue_rob_id,
    input  logic [4:0]  rs1_id,
    input  logic [4:0]  rs2_id,
    output logic [31:0] rs1_val,
    output logic [31:0] rs2_val,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic [3:0]  rs1_tag,
    output logic [3:0]  rs2_tag,
    input  logic        commit_en,
    input  logic [4:0]  commit_rd,
    input  logic [3:0]  commit_rob_id,
    input  logic [31:0] commit_val
);

    logic [31:0] val_reg  [32];
    logic        busy_reg [32];
    logic [3:0]  tag_reg  [32];

    // x0 is never written, so after reset its entry stays zero; the read
    // ports additionally force zero for index 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                val_reg[i]  <= '0;
                busy_reg[i] <= 1'b0;
                tag_reg[i]  <= '0;
            end
        end else if (rdy) begin
            for (int i = 1; i < 32; i++) begin
                // The value write happens even under clear: the retiring
                // instruction is older than the mispredicted branch.
                if (commit_en && commit_rd == 5'(i)) begin
                    val_reg[i] <= commit_val;
                end

                if (clear) begin
                    busy_reg[i] <= 1'b0;
                end else if (issue_en && issue_rd == 5'(i)) begin
                    // A new writer supersedes any commit to the same register.
                    busy_reg[i] <= 1'b1;
                    tag_reg[i]  <= issue_rob_id;
                end else if (commit_en && commit_rd == 5'(i) &&
                             busy_reg[i] && tag_reg[i] == commit_rob_id) begin
                    // Only the youngest writer may release the register;
                    // an older commit leaves a later rename pending.
                    busy_reg[i] <= 1'b0;
                end
            end
        end
    end

    // Two identical read ports, built from a common description.
    logic [4:0]  rd_id   [2];
    logic [31:0] rd_val  [2];
    logic        rd_busy [2];
    logic [3:0]  rd_tag  [2];

    assign rd_id[0] = rs1_id;
    assign rd_id[1] = rs2_id;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read_port
            logic bypass_hit;

`ifdef RF_COMMIT_BYPASS_EN
            assign bypass_hit = rdy && commit_en && rd_id[gi] != 5'd0 &&
                                commit_rd == rd_id[gi] &&
                                busy_reg[rd_id[gi]] &&
                                tag_reg[rd_id[gi]] == commit_rob_id;
`else
            assign bypass_hit = 1'b0;
`endif

            always_comb begin
                rd_val[gi]  = '0;
                rd_busy[gi] = 1'b0;
                rd_tag[gi]  = '0;
                if (rd_id[gi] != 5'd0) begin
                    rd_tag[gi] = tag_reg[rd_id[gi]];
                    if (bypass_hit) begin
                        rd_val[gi]  = commit_val;
                        rd_busy[gi] = 1'b0;
                    end else begin
                        rd_val[gi]  = val_reg[rd_id[gi]];
                        rd_busy[gi] = busy_reg[rd_id[gi]];
                    end
                end
            end
        end
    endgenerate

    assign rs1_val  = rd_val[0];
    assign rs1_busy = rd_busy[0];
    assign rs1_tag  = rd_tag[0];
    assign rs2_val  = rd_val[1];
    assign rs2_busy = rd_busy[1];
    assign rs2_tag  = rd_tag[1];

endmodule

// File: tb/tb_rename_reg_file.sv
// ---------------------------------------------------------------------------
// tb_rename_reg_file
//
// Directed bench for rename_reg_file: reset state, x0 handling, issue/commit
// visibility, tag-mismatch commits, same-cycle issue+commit, clear with a
// concurrent commit, rdy freeze and the optional same-cycle commit bypass
// (RF_COMMIT_BYPASS_EN).
// ---------------------------------------------------------------------------
module tb_rename_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic [3:0]  issue_rob_id;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [3:0]  rs1_tag;
    logic [3:0]  rs2_tag;
    logic        commit_en;
    logic [4:0]  commit_rd;
    logic [3:0]  commit_rob_id;
    logic [31:0] commit_val;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rename_reg_file dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .clear        (clear),
        .issue_en     (issue_en),
        .issue_rd     (issue_rd),
        .issue_rob_id (issue_rob_id),
        .rs1_id       (rs1_id),
        .rs2_id       (rs2_id),
        .rs1_val      (rs1_val),
        .rs2_val      (rs2_val),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .rs1_tag      (rs1_tag),
        .rs2_tag      (rs2_tag),
        .commit_en    (commit_en),
        .commit_rd    (commit_rd),
        .commit_rob_id(commit_rob_id),
        .commit_val   (commit_val)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
        end
    endtask

    task automatic idle();
        rdy           = 1'b1;
        clear         = 1'b0;
        issue_en      = 1'b0;
        issue_rd      = '0;
        issue_rob_id  = '0;
        commit_en     = 1'b0;
        commit_rd     = '0;
        commit_rob_id = '0;
        commit_val    = '0;
    endtask

    // Apply the currently driven inputs across one rising edge, then return
    // the control inputs to idle so reads show only registered state.
    task automatic cycle();
        $display("txn t=%0t rst=%0b rdy=%0b clr=%0b iss=%0b x%0d/%0d com=%0b x%0d/%0d val=%08h",
                 $time, rst, rdy, clear, issue_en, issue_rd, issue_rob_id,
                 commit_en, commit_rd, commit_rob_id, commit_val);
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [3:0] tag);
        issue_en = 1'b1; issue_rd = rd; issue_rob_id = tag;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [3:0] tag, input logic [31:0] v);
        commit_en = 1'b1; commit_rd = rd; commit_rob_id = tag; commit_val = v;
    endtask

    initial begin
        idle();
        rs1_id = '0;
        rs2_id = '0;
        rst = 1'b1;
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;

        // Reset state
        rs1_id = 5'd5; rs2_id = 5'd31; #1;
        check("rst_x5_val",   rs1_val,  32'h0);
        check("rst_x5_busy",  32'(rs1_busy), 32'h0);
        check("rst_x5_tag",   32'(rs1_tag),  32'h0);
        check("rst_x31_val",  rs2_val,  32'h0);

        // x0 ignores issue and commit
        issue(5'd0, 4'd3); cycle();
        commit(5'd0, 4'd0, 32'hFF); cycle();
        rs1_id = 5'd0; #1;
        check("x0_val",  rs1_val,  32'h0);
        check("x0_busy", 32'(rs1_busy), 32'h0);
        check("x0_tag",  32'(rs1_tag),  32'h0);

        // Issue then commit with matching tag
        issue(5'd3, 4'd7); cycle();
        rs1_id = 5'd3; #1;
        check("x3_iss_busy", 32'(rs1_busy), 32'h1);
        check("x3_iss_tag",  32'(rs1_tag),  32'h7);
        check("x3_iss_val",  rs1_val, 32'h0);
        commit(5'd3, 4'd7, 32'hDEADBEEF); cycle();
        check("x3_com_busy", 32'(rs1_busy), 32'h0);
        check("x3_com_val",  rs1_val, 32'hDEADBEEF);

        // Two writers in flight: older commit keeps the younger rename
        issue(5'd4, 4'd2); cycle();
        issue(5'd4, 4'd5); cycle();
        commit(5'd4, 4'd2, 32'h11); cycle();
        rs1_id = 5'd4; #1;
        check("x4_old_val",  rs1_val, 32'h11);
        check("x4_old_busy", 32'(rs1_busy), 32'h1);
        check("x4_old_tag",  32'(rs1_tag),  32'h5);
        commit(5'd4, 4'd5, 32'h22); cycle();
        check("x4_new_busy", 32'(rs1_busy), 32'h0);
        check("x4_new_val",  rs1_val, 32'h22);

        // Same-cycle issue and commit to one register
        issue(5'd6, 4'd9); commit(5'd6, 4'd1, 32'hAB); cycle();
        rs2_id = 5'd6; #1;
        check("x6_val",  rs2_val, 32'hAB);
        check("x6_busy", 32'(rs2_busy), 32'h1);
        check("x6_tag",  32'(rs2_tag),  32'h9);

        // Clear with concurrent commit and issue
        issue(5'd1, 4'd4); cycle();
        issue(5'd2, 4'd8); cycle();
        rs1_id = 5'd1; rs2_id = 5'd2; #1;
        check("x1_pre_busy", 32'(rs1_busy), 32'h1);
        check("x2_pre_busy", 32'(rs2_busy), 32'h1);
        clear = 1'b1; commit(5'd1, 4'd4, 32'h55); issue(5'd7, 4'd3); cycle();
        check("clr_x1_val",  rs1_val, 32'h55);
        check("clr_x1_busy", 32'(rs1_busy), 32'h0);
        check("clr_x2_busy", 32'(rs2_busy), 32'h0);
        rs1_id = 5'd7; #1;
        check("clr_x7_busy", 32'(rs1_busy), 32'h0);

        // Tag mismatch commit, including the top tag value
        issue(5'd10, 4'd15); cycle();
        commit(5'd10, 4'd14, 32'h77); cycle();
        rs1_id = 5'd10; #1;
        check("x10_val",  rs1_val, 32'h77);
        check("x10_busy", 32'(rs1_busy), 32'h1);
        check("x10_tag",  32'(rs1_tag),  32'hF);

        // rdy=0 freezes issue, commit and clear
        issue(5'd9, 4'd12); cycle();
        rdy = 1'b0; issue(5'd11, 4'd6); cycle();
        rs1_id = 5'd11; #1;
        check("frz_x11_busy", 32'(rs1_busy), 32'h0);
        rdy = 1'b0; clear = 1'b1; commit(5'd9, 4'd12, 32'h1234); rs1_id = 5'd9; #1;
        check("frz_byp_busy", 32'(rs1_busy), 32'h1);
        check("frz_byp_val",  rs1_val, 32'h0);
        cycle();
        check("frz_x9_busy", 32'(rs1_busy), 32'h1);
        check("frz_x9_val",  rs1_val, 32'h0);
        check("frz_x9_tag",  32'(rs1_tag), 32'hC);

        // Commit bypass on a matching tag
        commit(5'd9, 4'd12, 32'h1234); rs1_id = 5'd9; #1;
`ifdef RF_COMMIT_BYPASS_EN
        check("byp_val",  rs1_val, 32'h1234);
        check("byp_busy", 32'(rs1_busy), 32'h0);
`else
        check("nobyp_val",  rs1_val, 32'h0);
        check("nobyp_busy", 32'(rs1_busy), 32'h1);
        check("nobyp_tag",  32'(rs1_tag),  32'hC);
`endif
        cycle();
        check("x9_com_val",  rs1_val, 32'h1234);
        check("x9_com_busy", 32'(rs1_busy), 32'h0);

        // No bypass on a tag mismatch
        issue(5'd12, 4'd3); cycle();
        commit(5'd12, 4'd4, 32'h99); rs2_id = 5'd12; #1;
        check("mis_byp_busy", 32'(rs2_busy), 32'h1);
        check("mis_byp_val",  rs2_val, 32'h0);
        cycle();
        check("x12_val", rs2_val, 32'h99);

        // Reset overrides pending work
        rst = 1'b1; commit(5'd3, 4'd0, 32'h5); cycle();
        rst = 1'b0;
        rs1_id = 5'd3; rs2_id = 5'd12; #1;
        check("rst2_x3_val",   rs1_val, 32'h0);
        check("rst2_x12_busy", 32'(rs2_busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a stalled simulation.
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rename_reg_file.md
RENAME_REG_FILE -- requirements
Module: rename_reg_file

Interface
REQ-001 clk  input  1  system clock; all state updates on posedge clk.
REQ-002 rst  input  1  reset; synchronous, active-high.
REQ-003 rdy  input  1  global enable; when low, all state holds.
REQ-004 clear  input  1  mispredict flush from the reorder buffer.
REQ-005 issue_en  input  1  a dispatched instruction renames its destination this cycle.
REQ-006 issue_rd  input  5  architectural destination register of the dispatched instruction.
REQ-007 issue_rob_id  input  4  reorder-buffer slot allocated to the dispatched instruction.
REQ-008 rs1_id, rs2_id  input  5 each  source register indices, read combinationally.
REQ-009 rs1_val, rs2_val  output  32 each  architectural value of the source register.
REQ-010 rs1_busy, rs2_busy  output  1 each  source awaits an in-flight result.
REQ-011 rs1_tag, rs2_tag  output  4 each  reorder-buffer slot producing the source; meaningful only when busy=1.
REQ-012 commit_en  input  1  reorder buffer retires an instruction this cycle.
REQ-013 commit_rd  input  5  destination register of the retiring instruction.
REQ-014 commit_rob_id  input  4  slot of the retiring instruction.
REQ-015 commit_val  input  32  result value to write architecturally.

Function
REQ-016 Storage: 32 x 32-bit values, 32 busy bits, 32 x 4-bit tags.
REQ-017 x0: reads always return val=0, busy=0, tag=0; issue and commit targeting x0 are ignored.
REQ-018 Read ports are purely combinational and reflect state before this cycle's issue, so an instruction reading its own rd (e.g. add x1,x1,x2) sees the older mapping.
REQ-019 Issue (issue_en=1, issue_rd!=0, clear=0): busy[rd] <= 1 and tag[rd] <= issue_rob_id at the next edge; the value is unchanged.
REQ-020 Commit (commit_en=1, commit_rd!=0): val[rd] <= commit_val unconditionally.
REQ-021 On commit, busy[rd] is cleared only if busy[rd]=1 and tag[rd]==commit_rob_id; on a tag mismatch, busy and tag are kept because a younger writer is pending.
REQ-022 Issue and commit to the same rd in one cycle: the value write occurs, and the issue wins the busy and tag fields (busy=1, tag=issue_rob_id).
REQ-023 clear=1: all busy bits are cleared at the edge; tags are don't-care; issue is ignored that cycle.
REQ-024 A commit presented in the same cycle as clear SHALL still perform its value write.
REQ-025 Latency: issue and commit become visible on the read ports one cycle after the edge; there is no internal queueing and no backpressure.
REQ-026 rdy=0: no state changes, including clear, issue and commit; read ports remain valid.
REQ-027 Tag values wrap over 0..15 with no special casing; equality compares all 4 bits.

Reset
REQ-028 rst=1 at posedge clk: all 32 values <= 0, all busy <= 0, all tags <= 0; rst overrides rdy, clear, issue and commit.
REQ-029 During and after reset, all read outputs are 0 until written.

Configuration
REQ-030 Macro RF_COMMIT_BYPASS_EN.
- Defined: when commit_en=1, commit_rd==rsN_id!=0, busy[rsN]=1 and tag[rsN]==commit_rob_id, the read port returns rsN_val=commit_val and rsN_busy=0 in the same cycle.
- Undefined: no bypass; reads show pre-edge state only.
REQ-031 The bypass SHALL NOT fire when the tag mismatches or when rdy=0.

Verification
REQ-032 Reset, then read x5 -> val=0, busy=0; issue x0 with tag 3, then read x0 -> val=0, busy=0.
REQ-033 Issue x3 with tag 7; next cycle read x3 -> busy=1, tag=7; commit x3, tag 7, value 0xDEADBEEF; next cycle -> busy=0, val=0xDEADBEEF.
REQ-034 Issue x4 with tag 2, then issue x4 with tag 5; commit x4, tag 2, value 0x11 -> val=0x11, busy=1, tag=5; commit x4, tag 5, value 0x22 -> busy=0, val=0x22.
REQ-035 In one cycle, issue x6 with tag 9 and commit x6 with tag 1, value 0xAB -> next cycle val=0xAB, busy=1, tag=9.
REQ-036 Busy on x1 (tag 4) and x2 (tag 8); apply clear together with commit x1, tag 4, value 0x55 and issue x7 -> x1 val=0x55; x1, x2 and x7 all busy=0.
REQ-037 With RF_COMMIT_BYPASS_EN defined: x9 busy with tag 12; commit x9, tag 12, value 0x1234 while rs1_id=9 -> same cycle rs1_val=0x1234, rs1_busy=0. With the macro undefined -> rs1_busy=1, rs1_tag=12. With rdy=0 throughout -> no state change.
